// File: rtl/melody_pkg.sv
// Shared types for the melody sequencer: note codes, FSM states, table entry.
package melody_pkg;

  // Tone generator note encoding, C4 through C5.
  typedef enum logic [2:0] {
    NOTE_C4 = 3'b000,
    NOTE_D4 = 3'b001,
    NOTE_E4 = 3'b010,
    NOTE_F4 = 3'b011,
    NOTE_G4 = 3'b100,
    NOTE_A4 = 3'b101,
    NOTE_B4 = 3'b110,
    NOTE_C5 = 3'b111
  } note_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } seq_state_t;

  // One melody table entry; dur is in prescaler ticks, 0 means skip.
  typedef struct packed {
    note_t       note;
    logic [7:0]  dur;
  } entry_t;

endpackage

// File: rtl/melody_sequencer_tick_prescaler.sv
// Tempo prescaler: free-running 0..CLK_HZ/TICK_HZ-1 counter with a wrap tick.
module tick_prescaler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int TICKS = CLK_HZ / TICK_HZ;
  localparam int CW    = (TICKS < 2) ? 1 : $clog2(TICKS);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  generate
    if (TICKS < 2) begin : g_bad_ratio
      $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  logic [CW-1:0] count_q;

  // Count cycles within one tick; clr holds the phase at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            count_q <= '0;
    else if (clr)            count_q <= '0;
    else if (count_q == LAST) count_q <= '0;
    else                     count_q <= count_q + 1'b1;
  end

  assign tick = !clr && (count_q == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: plays (note, duration) entries from a writable table into the
// square-wave tone generator, inserting a fixed silent gap after each note.
// Optional build macro MELODY_LOOP_EN: repeat the melody until stop.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [$clog2(DEPTH):0]     seq_len,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [2:0]                 wr_note,
  input  logic [7:0]                 wr_dur,
  output logic [2:0]                 note,
  output logic                       note_en,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   cur_idx
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TICKS  = CLK_HZ / TICK_HZ;
  // The gap is timed in cycles so that the following LOAD cycle is part of the
  // silent interval: note_en low for exactly GAP_TICKS ticks between notes.
  localparam int GAP_CYC = (GAP_TICKS > 0) ? GAP_TICKS * TICKS - 1 : 1;
  localparam int GW      = $clog2(GAP_CYC + 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        tick_q, tick_d;
  logic [GW-1:0]     gap_q, gap_d;
  note_t             note_q, note_d;
  logic              done_q, done_d;
  logic              advance;
  logic              last;
  logic              tick;
  entry_t            entry_rd;
  entry_t            table_mem [DEPTH];

  tick_prescaler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (state_q != PLAY),
    .tick   (tick)
  );

  // Melody table: RAM-style, never cleared; a same-cycle read sees the old entry.
  always_ff @(posedge clk) begin
    if (wr_en) table_mem[wr_addr] <= entry_t'({wr_note, wr_dur});
  end

  assign entry_rd = table_mem[idx_q];
  assign last     = ({1'b0, idx_q} == (len_q - 1'b1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      tick_q  <= '0;
      gap_q   <= '0;
      note_q  <= NOTE_C4;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      note_q  <= note_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    tick_d  = tick_q;
    gap_d   = gap_q;
    note_d  = note_q;
    done_d  = 1'b0;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          len_d = seq_len;
          if (seq_len == '0) begin
            done_d = 1'b1;
          end else begin
            idx_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (entry_rd.dur == '0) begin
          advance = 1'b1;
        end else begin
          note_d  = entry_rd.note;
          tick_d  = entry_rd.dur;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          if (tick_q == 8'd1) begin
            if (GAP_TICKS > 0) begin
              gap_d   = GW'(GAP_CYC);
              state_d = GAP;
            end else begin
              advance = 1'b1;
            end
          end else begin
            tick_d = tick_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GW'(1)) advance = 1'b1;
        else                 gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (last) begin
        done_d = 1'b1;
`ifdef MELODY_LOOP_EN
        idx_d   = '0;
        len_d   = seq_len;
        state_d = (seq_len == '0) ? IDLE : LOAD;
`else
        state_d = IDLE;
`endif
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = LOAD;
      end
    end

    if (stop) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  // Outputs: enable follows PLAY directly, the rest come from registers.
  always_comb begin
    note    = note_q;
    note_en = (state_q == PLAY);
    busy    = (state_q != IDLE);
    done    = done_q;
    cur_idx = idx_q;
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer (10 cycles per tick, DEPTH=4, GAP_TICKS=1).
module tb_melody_sequencer;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int DEPTH     = 4;
  localparam int GAP_TICKS = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic [2:0] seq_len;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [2:0] wr_note;
  logic [7:0] wr_dur;
  logic [2:0] note;
  logic       note_en;
  logic       busy;
  logic       done;
  logic [1:0] cur_idx;

  melody_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .DEPTH    (DEPTH),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .stop   (stop),
    .seq_len(seq_len),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_note(wr_note),
    .wr_dur (wr_dur),
    .note   (note),
    .note_en(note_en),
    .busy   (busy),
    .done   (done),
    .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  // Expected-output vector: a run of cycles with constant outputs.
  typedef struct {
    logic        en;
    logic [2:0]  note;
    int unsigned cycles;
    logic [1:0]  idx;
  } seg_t;

  // Input vector: one table write.
  typedef struct {
    logic [1:0] addr;
    logic [2:0] note;
    logic [7:0] dur;
  } wr_t;

  seg_t seg_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_table();
    foreach (wr_q[i]) begin
      wr_en   = 1'b1;
      wr_addr = wr_q[i].addr;
      wr_note = wr_q[i].note;
      wr_dur  = wr_q[i].dur;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // Pulse start; returns at the negedge of the LOAD cycle.
  task automatic start_play(input logic [2:0] len, input string tag);
    seq_len = len;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s load busy", tag), busy, 1);
    chk($sformatf("%s load note_en", tag), note_en, 0);
    chk($sformatf("%s load idx", tag), cur_idx, 0);
  endtask

  task automatic run_segs(input string tag);
    foreach (seg_q[i]) begin
      for (int unsigned c = 0; c < seg_q[i].cycles; c++) begin
        @(negedge clk);
        chk($sformatf("%s seg%0d c%0d note_en", tag, i, c), note_en, seg_q[i].en);
        chk($sformatf("%s seg%0d c%0d busy", tag, i, c), busy, 1);
        chk($sformatf("%s seg%0d c%0d done", tag, i, c), done, 0);
        chk($sformatf("%s seg%0d c%0d idx", tag, i, c), cur_idx, seg_q[i].idx);
        if (seg_q[i].en)
          chk($sformatf("%s seg%0d c%0d note", tag, i, c), note, seg_q[i].note);
      end
    end
  endtask

  task automatic finish_check(input string tag);
    @(negedge clk);
    chk($sformatf("%s done pulse", tag), done, 1);
    chk($sformatf("%s end busy", tag), busy, 0);
    chk($sformatf("%s end note_en", tag), note_en, 0);
    @(negedge clk);
    chk($sformatf("%s done low", tag), done, 0);
    chk($sformatf("%s idle busy", tag), busy, 0);
  endtask

  task automatic load_gx_song();
    seg_q = '{'{1'b1, 3'b100, 20, 2'd0},
              '{1'b0, 3'b000,  9, 2'd0},
              '{1'b0, 3'b000,  1, 2'd1},
              '{1'b1, 3'b010, 10, 2'd1},
              '{1'b0, 3'b000,  9, 2'd1}};
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    seq_len = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_note = '0;
    wr_dur  = '0;
    repeat (2) @(negedge clk);
    chk("reset note", note, 0);
    chk("reset note_en", note_en, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset idx", cur_idx, 0);
    reset_n = 1'b1;
    @(negedge clk);

    wr_q = '{'{2'd0, 3'b100, 8'd2}, '{2'd1, 3'b010, 8'd1}};
    write_table();

    // Reset asserted mid-note clears outputs without waiting for a clock edge.
    start_play(3'd2, "rst");
    repeat (3) @(negedge clk);
    chk("rst pre note_en", note_en, 1);
    chk("rst pre note", note, 3'b100);
    #2 reset_n = 1'b0;
    #1;
    chk("rst async note", note, 0);
    chk("rst async note_en", note_en, 0);
    chk("rst async busy", busy, 0);
    chk("rst async done", done, 0);
    chk("rst async idx", cur_idx, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst idle%0d busy", i), busy, 0);
      chk($sformatf("rst idle%0d note_en", i), note_en, 0);
    end

    // Two-note melody; the table survived the reset.
    start_play(3'd2, "gx");
    load_gx_song();
    run_segs("gx");
    finish_check("gx");

    // Skipped zero-length entry.
    wr_q = '{'{2'd0, 3'b000, 8'd3}, '{2'd1, 3'b001, 8'd0}, '{2'd2, 3'b011, 8'd1}};
    write_table();
    start_play(3'd3, "skip");
    seg_q = '{'{1'b1, 3'b000, 30, 2'd0},
              '{1'b0, 3'b000,  9, 2'd0},
              '{1'b0, 3'b000,  1, 2'd1},
              '{1'b0, 3'b000,  1, 2'd2},
              '{1'b1, 3'b011, 10, 2'd2},
              '{1'b0, 3'b000,  9, 2'd2}};
    run_segs("skip");
    finish_check("skip");

    // Stop five cycles into the first note; start while busy is ignored.
    wr_q = '{'{2'd0, 3'b100, 8'd2}, '{2'd1, 3'b010, 8'd1}};
    write_table();
    start_play(3'd2, "stop");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stop play%0d note_en", c), note_en, 1);
      chk($sformatf("stop play%0d note", c), note, 3'b100);
      start   = (c == 2);
      seq_len = (c == 2) ? 3'd1 : 3'd2;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop note_en", note_en, 0);
    chk("stop busy", busy, 0);
    chk("stop done", done, 0);
    chk("stop note held", note, 3'b100);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk($sformatf("stop quiet%0d done", c), done, 0);
      chk($sformatf("stop quiet%0d busy", c), busy, 0);
    end
    start_play(3'd2, "replay");
    load_gx_song();
    run_segs("replay");
    finish_check("replay");

    // Empty melody, then start and stop together.
    seq_len = 3'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty done", done, 1);
    chk("empty busy", busy, 0);
    @(negedge clk);
    chk("empty done low", done, 0);
    chk("empty busy low", busy, 0);
    seq_len = 3'd2;
    start   = 1'b1;
    stop    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("ss%0d busy", c), busy, 0);
      chk($sformatf("ss%0d done", c), done, 0);
      chk($sformatf("ss%0d note_en", c), note_en, 0);
      @(negedge clk);
    end

    // Single-entry melody: repeats under MELODY_LOOP_EN, plays once otherwise.
    wr_q = '{'{2'd0, 3'b101, 8'd1}};
    write_table();
    start_play(3'd1, "one");
    seg_q = '{'{1'b1, 3'b101, 10, 2'd0}, '{1'b0, 3'b000, 9, 2'd0}};
`ifdef MELODY_LOOP_EN
    for (int k = 0; k < 3; k++) begin
      run_segs($sformatf("loop%0d", k));
      @(negedge clk);
      chk($sformatf("loop%0d done", k), done, 1);
      chk($sformatf("loop%0d busy", k), busy, 1);
      chk($sformatf("loop%0d note_en", k), note_en, 0);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("loop stop busy", busy, 0);
    chk("loop stop note_en", note_en, 0);
    chk("loop stop done", done, 0);
`else
    run_segs("one");
    finish_check("one");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
